// File: rtl/vfpu_stream_alu_pkg.sv
// Shared types for the streaming SIMD ALU: opcode enum and control/status bundles.
// Lengths and counts are carried at a fixed maximum width and resized at the top level.
package vfpu_alu_package;

  localparam int CNT_MAX_W = 32;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MIN  = 3'd2,
    MAX  = 3'd3,
    AND  = 3'd4,
    OR   = 3'd5,
    XOR  = 3'd6,
    PASS = 3'd7
  } alu_mode_t;

  typedef struct packed {
    logic                 start;
    alu_mode_t            mode;
    logic                 sat;
    logic [CNT_MAX_W-1:0] len;
  } ctrl_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [CNT_MAX_W-1:0] beat_cnt;
  } flags_t;

endpackage

// File: rtl/vfpu_alu_lane.sv
// One SIMD lane: folds NB_OPERANDS values left to right with the selected op.
// Signed saturation, when enabled, is applied after every ADD/SUB step.
module vfpu_alu_lane
  import vfpu_alu_package::*;
#(
  parameter int NB_OPERANDS = 2,
  parameter int LANE_WIDTH  = 8
) (
  input  logic [NB_OPERANDS-1:0][LANE_WIDTH-1:0] ops,
  input  alu_mode_t                              mode,
  input  logic                                   sat,
  output logic [LANE_WIDTH-1:0]                  res
);

  localparam logic [LANE_WIDTH-1:0] SMAX = {1'b0, {(LANE_WIDTH-1){1'b1}}};
  localparam logic [LANE_WIDTH-1:0] SMIN = {1'b1, {(LANE_WIDTH-1){1'b0}}};

  logic [LANE_WIDTH:0] wide;

  always_comb begin
    res  = ops[0];
    wide = '0;
    for (int k = 1; k < NB_OPERANDS; k++) begin
      case (mode)
        ADD, SUB: begin
          // One guard bit: overflow shows as the two top bits disagreeing.
          if (mode == ADD) wide = {res[LANE_WIDTH-1], res} + {ops[k][LANE_WIDTH-1], ops[k]};
          else             wide = {res[LANE_WIDTH-1], res} - {ops[k][LANE_WIDTH-1], ops[k]};
          if (sat && (wide[LANE_WIDTH] != wide[LANE_WIDTH-1]))
            res = wide[LANE_WIDTH] ? SMIN : SMAX;
          else
            res = wide[LANE_WIDTH-1:0];
        end
        MIN:     if ($signed(ops[k]) < $signed(res)) res = ops[k];
        MAX:     if ($signed(ops[k]) > $signed(res)) res = ops[k];
        AND:     res = res & ops[k];
        OR:      res = res | ops[k];
        XOR:     res = res ^ ops[k];
        default: res = res;
      endcase
    end
  end

endmodule

// File: rtl/vfpu_stream_alu.sv
// Job-based streaming SIMD ALU: fenced multi-operand accept, elastic result pipeline,
// IDLE/RUN/DRAIN job control with a done pulse after the last result handshake.
module vfpu_stream_alu
  import vfpu_alu_package::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NB_OPERANDS = 2,
  parameter int LANE_WIDTH  = 8,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                start_i,
  input  logic [2:0]                          mode_i,
  input  logic                                sat_i,
  input  logic [CNT_WIDTH-1:0]                len_i,
  input  logic [NB_OPERANDS-1:0]              op_valid_i,
  output logic [NB_OPERANDS-1:0]              op_ready_o,
  input  logic [NB_OPERANDS*DATA_WIDTH-1:0]   op_data_i,
  input  logic [NB_OPERANDS*DATA_WIDTH/8-1:0] op_strb_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [DATA_WIDTH-1:0]               res_data_o,
  output logic [DATA_WIDTH/8-1:0]             res_strb_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [CNT_WIDTH-1:0]                beat_cnt_o
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int SB        = DATA_WIDTH / 8;
  localparam logic [PIPE_STAGES:1] ONLY_TAIL = PIPE_STAGES'(1) << (PIPE_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               state_q, state_d;
  ctrl_t                ctrl_in;
  flags_t               flags_q;
  logic                 done_d;
  alu_mode_t            mode_q;
  logic                 sat_q;
  logic [CNT_MAX_W-1:0] len_q;
  logic [CNT_MAX_W-1:0] beat_next;

  logic [NUM_LANES-1:0][LANE_WIDTH-1:0] alu_data;
  logic [SB-1:0]                        alu_strb;

  logic [PIPE_STAGES:1]                 vld_pipe, vld_in, free;
  logic [PIPE_STAGES:1][DATA_WIDTH-1:0] data_pipe, data_in;
  logic [PIPE_STAGES:1][SB-1:0]         strb_pipe, strb_in;

  logic accept, res_hs, last_hs;

  assign ctrl_in.start = start_i;
  assign ctrl_in.mode  = alu_mode_t'(mode_i);
  assign ctrl_in.sat   = sat_i;
  assign ctrl_in.len   = CNT_MAX_W'(len_i);

  // ---------------- lanes ----------------
  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    logic [NB_OPERANDS-1:0][LANE_WIDTH-1:0] ops;
    for (genvar k = 0; k < NB_OPERANDS; k++) begin : g_op
      assign ops[k] = op_data_i[k*DATA_WIDTH + j*LANE_WIDTH +: LANE_WIDTH];
    end
    vfpu_alu_lane #(.NB_OPERANDS(NB_OPERANDS), .LANE_WIDTH(LANE_WIDTH)) u_lane (
      .ops  (ops),
      .mode (mode_q),
      .sat  (sat_q),
      .res  (alu_data[j])
    );
  end

  always_comb begin
    alu_strb = '1;
    for (int k = 0; k < NB_OPERANDS; k++) alu_strb = alu_strb & op_strb_i[k*SB +: SB];
  end

  // ---------------- elastic pipeline ----------------
  // A stage may load when it, or any stage downstream of it, is empty, or the sink takes a beat.
  for (genvar i = 1; i <= PIPE_STAGES; i++) begin : g_free
    assign free[i] = res_ready_i || !(&vld_pipe[PIPE_STAGES:i]);
  end

  always_comb begin
    vld_in[1]  = accept;
    data_in[1] = alu_data;
    strb_in[1] = alu_strb;
    for (int i = 2; i <= PIPE_STAGES; i++) begin
      vld_in[i]  = vld_pipe[i-1];
      data_in[i] = data_pipe[i-1];
      strb_in[i] = strb_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
      strb_pipe <= '0;
    end else if (clear_i) begin
      vld_pipe  <= '0;
    end else begin
      for (int i = 1; i <= PIPE_STAGES; i++) begin
        if (free[i]) begin
          vld_pipe[i] <= vld_in[i];
          if (vld_in[i]) begin
            data_pipe[i] <= data_in[i];
            strb_pipe[i] <= strb_in[i];
          end
        end
      end
    end
  end

  assign res_valid_o = vld_pipe[PIPE_STAGES];
  assign res_data_o  = data_pipe[PIPE_STAGES];
  assign res_strb_o  = strb_pipe[PIPE_STAGES];
  assign res_hs      = res_valid_o && res_ready_i;
  assign last_hs     = res_hs && (vld_pipe == ONLY_TAIL);

  // ---------------- job control ----------------
  assign accept     = (state_q == S_RUN) && (&op_valid_i) && free[1];
  assign op_ready_o = {NB_OPERANDS{accept}};
  assign beat_next  = flags_q.beat_cnt + CNT_MAX_W'(1);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (ctrl_in.start) begin
        if (ctrl_in.len == '0) done_d  = 1'b1;
        else                   state_d = S_RUN;
      end
      S_RUN:   if (accept && (beat_next == len_q)) state_d = S_DRAIN;
      S_DRAIN: if (last_hs) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (clear_i) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      mode_q  <= ADD;
      sat_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q       <= state_d;
      flags_q.done  <= done_d;
      flags_q.busy  <= (state_d != S_IDLE);
      if (clear_i) begin
        flags_q.beat_cnt <= '0;
      end else if ((state_q == S_IDLE) && ctrl_in.start) begin
        flags_q.beat_cnt <= '0;
        mode_q           <= ctrl_in.mode;
        sat_q            <= ctrl_in.sat;
        len_q            <= ctrl_in.len;
      end else if (accept) begin
        flags_q.beat_cnt <= beat_next;
      end
    end
  end

  assign busy_o     = flags_q.busy;
  assign done_o     = flags_q.done;
  assign beat_cnt_o = flags_q.beat_cnt[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_vfpu_stream_alu.sv
// Directed bench for vfpu_stream_alu: a 2-operand default instance and a 3-operand instance.
module tb_vfpu_stream_alu;
  import vfpu_alu_package::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        clear, start, sat, res_ready, res_valid, busy, done;
  logic [2:0]  mode;
  logic [15:0] len, beat_cnt;
  logic [1:0]  op_valid, op_ready;
  logic [63:0] op_data;
  logic [7:0]  op_strb;
  logic [31:0] res_data;
  logic [3:0]  res_strb;

  // three-operand instance
  logic        t_clear, t_start, t_sat, t_res_ready, t_res_valid, t_busy, t_done;
  logic [2:0]  t_mode;
  logic [15:0] t_len, t_beat_cnt;
  logic [2:0]  t_valid, t_ready;
  logic [95:0] t_data;
  logic [11:0] t_strb;
  logic [31:0] t_res_data;
  logic [3:0]  t_res_strb;

  int checks = 0;
  int errors = 0;

  logic [31:0] d0 [16];
  logic [31:0] d1 [16];
  logic [31:0] expv [16];
  logic [3:0]  s0, s1, exp_strb;

  vfpu_stream_alu dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .mode_i(mode), .sat_i(sat),
    .len_i(len), .op_valid_i(op_valid), .op_ready_o(op_ready), .op_data_i(op_data),
    .op_strb_i(op_strb), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_strb_o(res_strb), .busy_o(busy), .done_o(done),
    .beat_cnt_o(beat_cnt)
  );

  vfpu_stream_alu #(.NB_OPERANDS(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .clear_i(t_clear), .start_i(t_start), .mode_i(t_mode),
    .sat_i(t_sat), .len_i(t_len), .op_valid_i(t_valid), .op_ready_o(t_ready),
    .op_data_i(t_data), .op_strb_i(t_strb), .res_valid_o(t_res_valid),
    .res_ready_i(t_res_ready), .res_data_o(t_res_data), .res_strb_o(t_res_strb),
    .busy_o(t_busy), .done_o(t_done), .beat_cnt_o(t_beat_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job on the default instance; data comes from d0/d1, expectations from expv.
  task automatic run_job(input logic [2:0] m, input logic sa, input int n, input bit rnd,
                         input string tag);
    int sent, got, first_acc, first_vld, last_hs, done_it, ndone;
    sent = 0; got = 0; first_acc = -1; first_vld = -1; last_hs = -1; done_it = -1; ndone = 0;
    mode = m; sat = sa; len = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, busy, 1);
    for (int it = 0; it < 400 && done_it < 0; it++) begin
      if (sent < n) begin
        op_valid = 2'b11;
        op_data  = {d1[sent], d0[sent]};
      end else op_valid = 2'b00;
      op_strb   = {s1, s0};
      res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (op_ready[0]) begin
        if (first_acc < 0) first_acc = it;
        sent++;
      end
      if (res_valid && first_vld < 0) first_vld = it;
      if (res_valid && res_ready) begin
        chk({tag, " data"}, res_data, (got < 16) ? expv[got] : 32'hxxxx_xxxx);
        chk({tag, " strb"}, res_strb, exp_strb);
        got++;
        last_hs = it;
      end
      if (done) begin
        ndone++;
        done_it = it;
      end
      @(negedge clk);
    end
    op_valid = 2'b00;
    chk({tag, " latency"}, first_vld - first_acc, 2);
    chk({tag, " count"}, got, n);
    chk({tag, " done_once"}, ndone, 1);
    chk({tag, " done_after_last"}, done_it, last_hs + 1);
    chk({tag, " beat_cnt"}, beat_cnt, n);
    chk({tag, " idle"}, busy, 0);
    chk({tag, " done_pulse"}, done, 0);
  endtask

  task automatic run3(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] exp, input string tag);
    t_mode = m; t_len = 16'd1; t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    t_valid = 3'b111;
    t_data  = {c, b, a};
    #1;
    chk({tag, " ready"}, t_ready, 3'b111);
    @(negedge clk);
    t_valid = 3'b000;
    for (int i = 0; i < 10 && !t_res_valid; i++) @(negedge clk);
    chk({tag, " valid"}, t_res_valid, 1);
    chk({tag, " data"}, t_res_data, exp);
    @(negedge clk);
    chk({tag, " done"}, t_done, 1);
  endtask

  initial begin
    int nd;
    clear = 0; start = 0; sat = 0; res_ready = 1; mode = 3'd0; len = '0;
    op_valid = 2'b11; op_data = '0; op_strb = '1;
    t_clear = 0; t_start = 0; t_sat = 0; t_res_ready = 1; t_mode = 3'd0; t_len = '0;
    t_valid = '0; t_data = '0; t_strb = '1;
    s0 = 4'hF; s1 = 4'hF; exp_strb = 4'hF;

    // reset state
    @(negedge clk);
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", res_data, 0);
    chk("rst res_strb", res_strb, 0);
    chk("rst op_ready", op_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst beat_cnt", beat_cnt, 0);
    rst = 0;
    op_valid = 2'b00;
    @(negedge clk);

    // basic ADD stream
    for (int i = 0; i < 4; i++) begin
      d0[i] = 32'h0102_0304; d1[i] = 32'h1020_3040; expv[i] = 32'h1122_3344;
    end
    run_job(3'(ADD), 1'b0, 4, 1'b0, "add4");

    // saturation on/off
    d0[0] = 32'h0000_807F; d1[0] = 32'h0000_FF01;
    expv[0] = 32'h0000_807F;
    run_job(3'(ADD), 1'b1, 1, 1'b0, "add_sat");
    expv[0] = 32'h0000_7F80;
    run_job(3'(ADD), 1'b0, 1, 1'b0, "add_wrap");
    d0[0] = 32'h0000_7F80; d1[0] = 32'h0000_FF01;
    expv[0] = 32'h0000_7F80;
    run_job(3'(SUB), 1'b1, 1, 1'b0, "sub_sat");

    // logic / compare ops, with strobe merging
    s1 = 4'hD; exp_strb = 4'hD;
    d0[0] = 32'hF0F0_AA55; d1[0] = 32'h0FF0_55AA; expv[0] = 32'hFF00_FFFF;
    d0[1] = 32'h1234_5678; d1[1] = 32'h1234_5678; expv[1] = 32'h0000_0000;
    run_job(3'(XOR), 1'b1, 2, 1'b0, "xor_strb");
    s1 = 4'hF; exp_strb = 4'hF;
    d0[0] = 32'h7F80_0102; d1[0] = 32'h8001_0201; expv[0] = 32'h7F01_0202;
    run_job(3'(MAX), 1'b0, 1, 1'b0, "max");

    // backpressure, 16 distinct beats
    for (int i = 0; i < 16; i++) begin
      d0[i]   = {4{8'(i)}};
      d1[i]   = 32'h0101_0101;
      expv[i] = {4{8'(i + 1)}};
    end
    run_job(3'(ADD), 1'b0, 16, 1'b1, "bp16");

    // accept fence, then clear mid-run
    mode = 3'(ADD); len = 16'd4; start = 1;
    @(negedge clk);
    start = 0;
    op_valid = 2'b01; res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fence op_ready", op_ready, 2'b00);
      chk("fence res_valid", res_valid, 0);
      chk("fence beat_cnt", beat_cnt, 0);
      @(negedge clk);
    end
    op_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    op_valid = 2'b00;
    chk("partial beat_cnt", beat_cnt, 2);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clear busy", busy, 0);
    chk("clear beat_cnt", beat_cnt, 0);
    chk("clear res_valid", res_valid, 0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("clear no_done", nd, 0);
    res_ready = 1;

    // zero-length job
    len = 16'd0; start = 1;
    @(negedge clk);
    start = 0;
    chk("len0 done", done, 1);
    chk("len0 busy", busy, 0);
    @(negedge clk);
    chk("len0 done_pulse", done, 0);
    chk("len0 busy_after", busy, 0);

    // reset mid-job
    len = 16'd4; start = 1;
    @(negedge clk);
    start = 0;
    op_valid = 2'b11; res_ready = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("midrst op_ready", op_ready, 0);
    chk("midrst busy", busy, 0);
    chk("midrst beat_cnt", beat_cnt, 0);
    chk("midrst res_valid", res_valid, 0);
    op_valid = 2'b00;
    @(negedge clk);
    rst = 0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    chk("midrst quiet", nd, 0);
    res_ready = 1;

    // three operands
    run3(3'(SUB), 32'h0000_000A, 32'h0000_0003, 32'h0000_0002, 32'h0000_0005, "sub3");
    run3(3'(MIN), 32'h0000_00F6, 32'h0000_0003, 32'h0000_0002, 32'h0000_00F6, "min3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
